// File: rtl/sdram_pkg.sv
// Shared definitions for the SDRAM clocking/bring-up path: supervisor FSM
// state encodings and elaboration-time sizing helpers.
package sdram_pkg;

  typedef enum logic [2:0] {
    ST_WAIT_LOCK = 3'd0,
    ST_POWERUP   = 3'd1,
    ST_INIT_REQ  = 3'd2,
    ST_INIT_WAIT = 3'd3,
    ST_READY     = 3'd4,
    ST_ERROR     = 3'd5
  } sdram_state_e;

  // Ceiling log2; clog2(0) = clog2(1) = 0.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned     result;
    longint unsigned span;
    result = 0;
    span   = 1;
    while (span < longint'(value)) begin
      span   = span << 1;
      result = result + 1;
    end
    return result;
  endfunction

  // Number of clk cycles covering the SDRAM power-up stable-clock wait.
  function automatic int unsigned powerup_cycles(input int unsigned clk_hz,
                                                 input int unsigned wait_us);
    return (clk_hz / 1000000) * wait_us;
  endfunction

  function automatic int unsigned max3(input int unsigned a,
                                       input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer for level signals crossing into clk_i.
module sync_2ff #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  // Two back-to-back flops; the first may go metastable, the second settles.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/sdram_pll_supervisor.sv
// Turns PLL lock status into an SDRAM controller bring-up sequence:
// lock debounce, power-up wait, init handshake with timeout, and lock-loss
// recovery with event counting.
module sdram_pll_supervisor
  import sdram_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ         = 100000000,
  parameter int unsigned POWERUP_US          = 100,
  parameter int unsigned LOCK_STABLE_CYCLES  = 256,
  parameter int unsigned INIT_TIMEOUT_CYCLES = 65535
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pll_locked,
  input  logic       init_done,
  output logic       ctrl_rst,
  output logic       init_start,
  output logic       ready,
  output logic       lock_lost,
  output logic       init_error,
  output logic [7:0] relock_count,
  output logic [2:0] state
);

  localparam int unsigned POWERUP_CYCLES = powerup_cycles(CLK_FREQ_HZ, POWERUP_US);
  localparam int unsigned CNT_MAX = max3(POWERUP_CYCLES, LOCK_STABLE_CYCLES,
                                         INIT_TIMEOUT_CYCLES);
  localparam int unsigned CNT_W   = clog2(CNT_MAX) + 1;

  localparam logic [CNT_W-1:0] LOCK_LAST    = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] POWERUP_LAST = CNT_W'(POWERUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(INIT_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

  logic lk_s;

  sync_2ff #(
    .WIDTH(1)
  ) u_lock_sync (
    .clk_i (clk),
    .rst_ni(rst),
    .d_i   (pll_locked),
    .q_o   (lk_s)
  );

  sdram_state_e     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ctrl_rst_q, ctrl_rst_d;
  logic             init_start_q, init_start_d;
  logic             ready_q, ready_d;
  logic             lock_lost_q, lock_lost_d;
  logic             init_error_q, init_error_d;
  logic [7:0]       relock_q, relock_d;

  // State, shared counter and all registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_WAIT_LOCK;
      cnt_q        <= '0;
      ctrl_rst_q   <= 1'b1;
      init_start_q <= 1'b0;
      ready_q      <= 1'b0;
      lock_lost_q  <= 1'b0;
      init_error_q <= 1'b0;
      relock_q     <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      ctrl_rst_q   <= ctrl_rst_d;
      init_start_q <= init_start_d;
      ready_q      <= ready_d;
      lock_lost_q  <= lock_lost_d;
      init_error_q <= init_error_d;
      relock_q     <= relock_d;
    end
  end

  // Next state; lock loss overrides every in-state decision. Outputs are
  // decoded from the next state so the registered copies line up with state_q.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    lock_lost_d  = lock_lost_q;
    init_error_d = init_error_q;
    relock_d     = relock_q;

    if ((state_q != ST_WAIT_LOCK) && !lk_s) begin
      state_d = ST_WAIT_LOCK;
      cnt_d   = '0;
      if (relock_q != 8'hFF) relock_d = relock_q + 8'd1;
      if (state_q == ST_READY) lock_lost_d = 1'b1;
    end else begin
      case (state_q)
        ST_WAIT_LOCK: begin
          if (!lk_s) begin
            cnt_d = '0;
          end else if (cnt_q == LOCK_LAST) begin
            state_d = ST_POWERUP;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        ST_POWERUP: begin
          if (cnt_q == POWERUP_LAST) begin
            state_d = ST_INIT_REQ;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        ST_INIT_REQ: begin
          state_d = ST_INIT_WAIT;
          cnt_d   = '0;
        end
        ST_INIT_WAIT: begin
          if (init_done) begin
            state_d = ST_READY;
          end else if (cnt_q == TIMEOUT_LAST) begin
            state_d      = ST_ERROR;
            init_error_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        ST_READY: begin
          state_d = ST_READY;
        end
        ST_ERROR: begin
          state_d = ST_ERROR;
        end
        default: begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
        end
      endcase
    end

    ctrl_rst_d   = (state_d == ST_WAIT_LOCK) || (state_d == ST_POWERUP) ||
                   (state_d == ST_ERROR);
    init_start_d = (state_d == ST_INIT_REQ);
    ready_d      = (state_d == ST_READY);
  end

  assign ctrl_rst     = ctrl_rst_q;
  assign init_start   = init_start_q;
  assign ready        = ready_q;
  assign lock_lost    = lock_lost_q;
  assign init_error   = init_error_q;
  assign relock_count = relock_q;
  assign state        = state_q;

endmodule

// File: tb/tb_sdram_pll_supervisor.sv
// Self-checking bench for sdram_pll_supervisor: directed bring-up, glitch,
// lock-loss, timeout, priority, saturation and async-reset scenarios plus
// randomized lock/init traffic, all against a phase/age reference model.
module tb_sdram_pll_supervisor;

  localparam int unsigned CLK_HZ  = 10000000;
  localparam int unsigned PU_US   = 2;
  localparam int unsigned STABLE  = 8;
  localparam int unsigned TIMEOUT = 16;
  localparam int          PU_CYC  = (CLK_HZ / 1000000) * PU_US;

  logic       clk;
  logic       rst;
  logic       pll_locked;
  logic       init_done;
  logic       ctrl_rst;
  logic       init_start;
  logic       ready;
  logic       lock_lost;
  logic       init_error;
  logic [7:0] relock_count;
  logic [2:0] state;

  sdram_pll_supervisor #(
    .CLK_FREQ_HZ        (CLK_HZ),
    .POWERUP_US         (PU_US),
    .LOCK_STABLE_CYCLES (STABLE),
    .INIT_TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .pll_locked  (pll_locked),
    .init_done   (init_done),
    .ctrl_rst    (ctrl_rst),
    .init_start  (init_start),
    .ready       (ready),
    .lock_lost   (lock_lost),
    .init_error  (init_error),
    .relock_count(relock_count),
    .state       (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: phase numbers as listed for the bring-up sequence,
  // age = cycles spent in the phase (or consecutive locked cycles).
  int m_phase, m_age, m_relock;
  bit m_lost, m_err, m_s1, m_s2;

  task automatic model_reset();
    m_phase = 0; m_age = 0; m_relock = 0;
    m_lost = 0; m_err = 0; m_s1 = 0; m_s2 = 0;
  endtask

  task automatic model_edge(input bit pll, input bit done);
    bit lk;
    lk   = m_s2;
    m_s2 = m_s1;
    m_s1 = pll;
    if (m_phase != 0 && !lk) begin
      if (m_phase == 4) m_lost = 1;
      if (m_relock < 255) m_relock++;
      m_phase = 0;
      m_age   = 0;
    end else begin
      case (m_phase)
        0: begin
          m_age = lk ? m_age + 1 : 0;
          if (m_age >= int'(STABLE)) begin m_phase = 1; m_age = 0; end
        end
        1: begin
          m_age++;
          if (m_age >= PU_CYC) begin m_phase = 2; m_age = 0; end
        end
        2: begin m_phase = 3; m_age = 0; end
        3: begin
          if (done) m_phase = 4;
          else begin
            m_age++;
            if (m_age >= int'(TIMEOUT)) begin m_phase = 5; m_err = 1; end
          end
        end
        default: ;
      endcase
    end
  endtask

  task automatic compare_all();
    check_eq("state",      32'(state),        32'(m_phase));
    check_eq("ctrl_rst",   32'(ctrl_rst),     32'(m_phase == 0 || m_phase == 1 || m_phase == 5));
    check_eq("init_start", 32'(init_start),   32'(m_phase == 2));
    check_eq("ready",      32'(ready),        32'(m_phase == 4));
    check_eq("lock_lost",  32'(lock_lost),    32'(m_lost));
    check_eq("init_error", 32'(init_error),   32'(m_err));
    check_eq("relock",     32'(relock_count), 32'(m_relock));
  endtask

  int cyc;
  int starts;
  int first_start;
  int first_seen[6];
  int done_delay;
  int wait_age;

  task automatic clear_marks();
    cyc = 0; starts = 0; first_start = -1; wait_age = 0;
    for (int i = 0; i < 6; i++) first_seen[i] = -1;
  endtask

  // Drive inputs away from the edge, advance one clock, model it, compare.
  task automatic step(input bit pll, input bit done);
    pll_locked = pll;
    init_done  = done;
    @(posedge clk);
    if (rst) model_edge(pll, done);
    else     model_reset();
    cyc++;
    #1;
    compare_all();
    if (init_start === 1'b1) begin
      starts++;
      if (first_start < 0) first_start = cyc;
    end
    if (!$isunknown(state) && state < 3'd6 && first_seen[int'(state)] < 0)
      first_seen[int'(state)] = cyc;
    @(negedge clk);
  endtask

  // Behaves like an SDRAM controller: init_done rises done_delay cycles into
  // the wait and stays high while usable.
  task automatic cycle(input bit pll);
    bit done;
    if (m_phase == 3)      wait_age++;
    else if (m_phase != 4) wait_age = 0;
    done = (m_phase == 3 || m_phase == 4) && (wait_age >= done_delay);
    step(pll, done);
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    rst = 1'b1;
    clear_marks();
  endtask

  task automatic run_to_phase(input int phase, input string tag);
    int n;
    n = 0;
    while (m_phase != phase && n < 80) begin
      cycle(1'b1);
      n++;
    end
    if (m_phase != phase) check_eq(tag, 32'(state), 32'(phase));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; pll_locked = 1'b0; init_done = 1'b0;
    done_delay = 3;
    model_reset();
    clear_marks();
    #1 rst = 1'b0;
    #1;
    check_eq("rst_state",      32'(state),        32'd0);
    check_eq("rst_ctrl_rst",   32'(ctrl_rst),     32'd1);
    check_eq("rst_init_start", 32'(init_start),   32'd0);
    check_eq("rst_ready",      32'(ready),        32'd0);
    check_eq("rst_relock",     32'(relock_count), 32'd0);

    // Normal bring-up.
    apply_reset();
    done_delay = 3;
    repeat (45) cycle(1'b1);
    check_eq("b_start_cycle", 32'(first_start), 32'(2 + STABLE + PU_CYC));
    check_eq("b_start_count", 32'(starts), 32'd1);
    check_eq("b_ready",       32'(ready), 32'd1);
    check_eq("b_ctrl_rst",    32'(ctrl_rst), 32'd0);

    // Glitch during debounce.
    apply_reset();
    repeat (5) cycle(1'b1);
    cycle(1'b0);
    repeat (40) cycle(1'b1);
    check_eq("c_powerup_cycle", 32'(first_seen[1]), 32'(6 + 2 + STABLE));
    check_eq("c_relock",        32'(relock_count), 32'd0);

    // Lock loss in READY, then full re-sequence.
    apply_reset();
    done_delay = 3;
    repeat (45) cycle(1'b1);
    starts = 0;
    cycle(1'b0);
    cycle(1'b0);
    check_eq("d_ready_hold", 32'(ready), 32'd1);
    cycle(1'b0);
    check_eq("d_ready_drop", 32'(ready), 32'd0);
    check_eq("d_ctrl_rst",   32'(ctrl_rst), 32'd1);
    repeat (45) cycle(1'b1);
    check_eq("d_lock_lost", 32'(lock_lost), 32'd1);
    check_eq("d_relock",    32'(relock_count), 32'd1);
    check_eq("d_restart",   32'(starts), 32'd1);
    check_eq("d_ready",     32'(ready), 32'd1);

    // Init timeout.
    apply_reset();
    done_delay = 1000;
    repeat (60) cycle(1'b1);
    check_eq("e_timeout_len", 32'(first_seen[5] - first_seen[3]), 32'(TIMEOUT));
    check_eq("e_init_error",  32'(init_error), 32'd1);
    check_eq("e_ctrl_rst",    32'(ctrl_rst), 32'd1);
    check_eq("e_ready_never", 32'(first_seen[4]), 32'hFFFF_FFFF);

    // Lock loss coincident with init_done.
    apply_reset();
    done_delay = 1000;
    run_to_phase(3, "f_reach_wait");
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    check_eq("f_loss_vs_done", 32'(state), 32'd0);
    check_eq("f_lost_flag",    32'(lock_lost), 32'd0);

    // Lock loss coincident with timeout.
    apply_reset();
    run_to_phase(3, "f_reach_wait2");
    repeat (int'(TIMEOUT) - 3) step(1'b1, 1'b0);
    repeat (3) step(1'b0, 1'b0);
    check_eq("f_loss_vs_to", 32'(state), 32'd0);
    check_eq("f_no_error",   32'(init_error), 32'd0);

    // init_done coincident with timeout.
    apply_reset();
    run_to_phase(3, "f_reach_wait3");
    repeat (int'(TIMEOUT) - 1) step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    check_eq("f_done_vs_to", 32'(state), 32'd4);
    check_eq("f_done_noerr", 32'(init_error), 32'd0);

    // Relock counter saturation.
    apply_reset();
    done_delay = 3;
    for (int i = 0; i < 300; i++) begin
      run_to_phase(1, "g_reach_pu");
      repeat (3) cycle(1'b0);
    end
    check_eq("g_saturate", 32'(relock_count), 32'd255);

    // Randomized lock traffic with occasional resets.
    apply_reset();
    for (int seg = 0; seg < 150; seg++) begin
      if ($urandom_range(0, 24) == 0) begin
        rst = 1'b0;
        step(1'b0, 1'b0);
        rst = 1'b1;
        wait_age = 0;
      end
      done_delay = $urandom_range(1, 18);
      repeat ($urandom_range(1, 50)) cycle(1'b1);
      repeat ($urandom_range(1, 4)) cycle(1'b0);
    end

    // Async reset mid-POWERUP with both sticky flags set.
    apply_reset();
    done_delay = 3;
    repeat (45) cycle(1'b1);
    repeat (3) cycle(1'b0);
    done_delay = 1000;
    repeat (60) cycle(1'b1);
    repeat (3) cycle(1'b0);
    run_to_phase(1, "i_reach_pu");
    repeat (4) cycle(1'b1);
    check_eq("i_pre_lost", 32'(lock_lost), 32'd1);
    check_eq("i_pre_err",  32'(init_error), 32'd1);
    pll_locked = 1'b1;
    init_done  = 1'b0;
    @(posedge clk);
    model_edge(1'b1, 1'b0);
    #1;
    compare_all();
    rst = 1'b0;
    #1;
    check_eq("i_state",      32'(state),        32'd0);
    check_eq("i_ctrl_rst",   32'(ctrl_rst),     32'd1);
    check_eq("i_init_start", 32'(init_start),   32'd0);
    check_eq("i_ready",      32'(ready),        32'd0);
    check_eq("i_lock_lost",  32'(lock_lost),    32'd0);
    check_eq("i_init_error", 32'(init_error),   32'd0);
    check_eq("i_relock",     32'(relock_count), 32'd0);
    model_reset();
    @(negedge clk);
    #1 rst = 1'b1;
    clear_marks();
    done_delay = 3;
    repeat (45) cycle(1'b1);
    check_eq("i_rebring_ready", 32'(ready), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
